// File: rtl/adder32_rr_scheduler_pkg.sv
// Shared types and widths for the round-robin scheduled 32-bit adder.
package adder32_rr_scheduler_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RES_W  = 33;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } operands_t;

endpackage

// File: rtl/ripple_carry_adder32.sv
// 32-bit ripple-carry adder; carry out lands in the top result bit.
module ripple_carry_adder32
    import adder32_rr_scheduler_pkg::*;
(
    input  logic [DATA_W-1:0] add1_i,
    input  logic [DATA_W-1:0] add2_i,
    output logic [RES_W-1:0]  result_o
);

    logic              carry;
    logic [DATA_W-1:0] sum;

    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            sum[i] = add1_i[i] ^ add2_i[i] ^ carry;
            carry  = (add1_i[i] & add2_i[i]) | (carry & (add1_i[i] ^ add2_i[i]));
        end
        result_o = {carry, sum};
    end

endmodule

// File: rtl/adder32_rr_scheduler.sv
// Round-robin arbiter sharing one ripple-carry adder among NUM_REQ requesters.
// Operands are held for SETTLE_CYCLES before the sum is captured.
module adder32_rr_scheduler
    import adder32_rr_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0]  op_a_i,
    input  logic [NUM_REQ*DATA_W-1:0]  op_b_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [RES_W-1:0]           rsp_result_o,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_found;
    logic [NUM_REQ-1:0] gnt_oh;
    operands_t         ops_q;
    logic [RES_W-1:0]  sum;
    logic [RES_W-1:0]  result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;

    // First valid requester at or after ptr, wrapping; returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic            found;
        logic [ID_W-1:0] idx;
        int unsigned     cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!found && valid[ID_W'(cand)]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        {gnt_found, gnt_idx} = rr_pick(req_valid_i, ptr_q);
        gnt_oh = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    assign accept = |(req_valid_i & req_ready_o);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = BUSY;
            BUSY:    if (cnt_q == '0)   state_d = DONE;
            DONE:    if (rsp_ready_i)   state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Grants only in IDLE and never while reset is held.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE:    if (rst_ni) req_ready_o = gnt_oh;
            DONE:    rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q    <= '0;
            id_q     <= '0;
            ops_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                ops_q.a <= op_a_i[32'(gnt_idx)*DATA_W +: DATA_W];
                ops_q.b <= op_b_i[32'(gnt_idx)*DATA_W +: DATA_W];
                id_q    <= gnt_idx;
                ptr_q   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
            end
            if (state_q == BUSY) begin
                if (cnt_q == '0) begin
                    result_q <= sum;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // Adder sees only the registered operands, so its inputs are stable while settling.
    ripple_carry_adder32 u_rca (
        .add1_i   (ops_q.a),
        .add2_i   (ops_q.b),
        .result_o (sum)
    );

    assign rsp_result_o = result_q;
    assign rsp_id_o     = id_q;

endmodule

// File: tb/tb_adder32_rr_scheduler.sv
// Scoreboard bench for adder32_rr_scheduler: directed scenarios plus randomized traffic.
module tb_adder32_rr_scheduler;

    localparam int unsigned N      = 4;
    localparam int unsigned SETTLE = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*32-1:0]  op_a;
    logic [N*32-1:0]  op_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [32:0]      rsp_result;
    logic [1:0]       rsp_id;

    adder32_rr_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_id_o     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [32:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   acc_id_log[$];
    int   acc_cyc_log[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   m_ptr    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Round-robin reference: first valid index at or after p, wrapping.
    function automatic int rr_ref(input logic [N-1:0] v, input int p);
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (p + k) % int'(N);
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Monitor: grant legality, response timing/content, and scoreboard upkeep.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic [N-1:0] acc;
        int           g;
        cyc++;
        if (!rst_n) begin
            chk("ready_in_reset", 64'(req_ready), 64'(0));
            sb.delete();
            m_ptr = 0;
        end else begin
            g = rr_ref(req_valid, m_ptr);
            exp_ready = (sb.size() == 0 && g >= 0) ? (N'(1) << g) : '0;
            chk("grant", 64'(req_ready), 64'(exp_ready));
            if (sb.size() == 0) begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
            end else if (cyc < sb[0].due) begin
                chk("rsp_early", 64'(rsp_valid), 64'(0));
            end else begin
                chk("rsp_valid", 64'(rsp_valid), 64'(1));
                if (rsp_valid) begin
                    chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                    chk("rsp_result", 64'(rsp_result), 64'(sb[0].res));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            acc = req_valid & req_ready;
            if (acc != '0) begin
                exp_t e;
                int   id;
                id = 0;
                for (int k = 0; k < int'(N); k++) if (acc[k]) id = k;
                e.id  = id;
                e.res = {1'b0, op_a[id*32 +: 32]} + {1'b0, op_b[id*32 +: 32]};
                e.due = cyc + int'(SETTLE) + 1;
                sb.push_back(e);
                acc_id_log.push_back(id);
                acc_cyc_log.push_back(cyc);
                m_ptr = (id + 1) % int'(N);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
        op_a[k*32 +: 32] = a;
        op_b[k*32 +: 32] = b;
    endtask

    task automatic wait_accepts(input string name, input int n0, input int cnt, input int budget);
        int t;
        t = 0;
        while (acc_id_log.size() < n0 + cnt && t < budget) begin
            step();
            t++;
        end
        if (acc_id_log.size() < n0 + cnt) chk(name, 64'(0), 64'(1));
    endtask

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b);
        int n0;
        n0 = acc_id_log.size();
        set_op(k, a, b);
        req_valid[k] = 1'b1;
        wait_accepts("issue_timeout", n0, 1, 50);
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp();
        int t;
        t = 0;
        while (!rsp_valid && t < 40) begin
            step();
            t++;
        end
        if (!rsp_valid) chk("rsp_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            step();
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    task automatic reset_pulse(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        rst_n     = 1'b0;
        req_valid = '1;
        op_a      = '0;
        op_b      = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_result", 64'(rsp_result), 64'(0));
        chk("reset_rsp_id", 64'(rsp_id), 64'(0));
        req_valid = '0;
        rst_n     = 1'b1;
        step();

        // Single request from requester 0; latency checked by the monitor.
        issue(0, 32'h29AF_2430, 32'h7A1B_9ABC);
        wait_rsp();
        chk("basic_result", 64'(rsp_result), 64'h0_A3CA_BEEC);
        chk("basic_id", 64'(rsp_id), 64'(0));
        wait_empty();

        // Carry out into bit 32.
        issue(1, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_rsp();
        chk("carry_result", 64'(rsp_result), 64'h1_0000_0000);
        wait_empty();

        // Backpressure: response must hold and no grant while others request.
        rsp_ready = 1'b0;
        issue(2, 32'h5555_5555, 32'hAAAA_AAAA);
        req_valid = 4'b1011;
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_result", 64'(rsp_result), 64'h0_FFFF_FFFF);
            chk("bp_id", 64'(rsp_id), 64'(2));
            chk("bp_no_ready", 64'(req_ready), 64'(0));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_empty();
        step();

        // Wrap-around: ptr is 3, requesters 0 and 2 valid -> 0 then 2.
        n0 = acc_id_log.size();
        req_valid = 4'b0101;
        wait_accepts("wrap_timeout", n0, 2, 60);
        req_valid = '0;
        if (acc_id_log.size() >= n0 + 2) begin
            chk("wrap_first", 64'(acc_id_log[n0]), 64'(0));
            chk("wrap_second", 64'(acc_id_log[n0 + 1]), 64'(2));
        end
        wait_empty();

        // Reset while BUSY with requester 2 in flight: no response, ptr back to 0.
        reset_pulse(2);
        issue(2, 32'h1234_5678, 32'h0000_0001);
        reset_pulse(1);
        for (int i = 0; i < int'(SETTLE) + 4; i++) begin
            chk("abandon_no_rsp", 64'(rsp_valid), 64'(0));
            step();
        end
        n0 = acc_id_log.size();
        req_valid = 4'b0110;
        wait_accepts("post_reset_timeout", n0, 2, 60);
        req_valid = '0;
        if (acc_id_log.size() >= n0 + 2) begin
            chk("post_reset_first", 64'(acc_id_log[n0]), 64'(1));
            chk("post_reset_second", 64'(acc_id_log[n0 + 1]), 64'(2));
        end
        wait_empty();

        // All requesters valid: order 0,1,2,3,0 with fixed spacing.
        reset_pulse(1);
        for (int k = 0; k < int'(N); k++) set_op(k, $urandom(), $urandom());
        n0 = acc_id_log.size();
        req_valid = '1;
        wait_accepts("rr_timeout", n0, 5, 80);
        req_valid = '0;
        if (acc_id_log.size() >= n0 + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("rr_order", 64'(acc_id_log[n0 + i]), 64'(i % int'(N)));
                if (i > 0)
                    chk("rr_spacing", 64'(acc_cyc_log[n0 + i] - acc_cyc_log[n0 + i - 1]),
                        64'(SETTLE + 2));
            end
        end
        wait_empty();

        // Randomized traffic with dropping requests, backpressure and rare resets.
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int k = 0; k < int'(N); k++) begin
                set_op(k, $urandom(), $urandom());
                if ($urandom_range(0, 7) == 0) op_a[k*32 +: 32] = 32'hFFFF_FFFF;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_empty();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
